// File: rtl/shader_dispatcher_pkg.sv
// Shared GPU definitions: dispatcher parameter defaults and FSM state encoding.
package gpu;

   localparam int COORD_BITS_D   = 8;
   localparam int PALETTE_BITS_D = 8;
   localparam int PIXEL_BITS_D   = 8;
   localparam int ADDR_BITS_D    = 12;

   typedef enum logic [2:0] {
      IDLE,
      R_FETCH,
      R_LATCH,
      RASTER,
      S_FETCH,
      S_LATCH,
      SHADE,
      DONE
   } dispatch_state_t;

endpackage

// File: rtl/shader_dispatcher_if.sv
// Dispatcher bus: frame control, voxel/palette RAM read ports, shader broadcast.
interface shader_dispatcher_if #(
   parameter int COORD_BITS   = gpu::COORD_BITS_D,
   parameter int PALETTE_BITS = gpu::PALETTE_BITS_D,
   parameter int PIXEL_BITS   = gpu::PIXEL_BITS_D,
   parameter int ADDR_BITS    = gpu::ADDR_BITS_D
) ();

   logic                                start;
   logic [ADDR_BITS:0]                  num_voxels;
   logic [PALETTE_BITS-1:0]             num_palette;
   logic                                vox_rd;
   logic [ADDR_BITS-1:0]                vox_addr;
   logic [3*COORD_BITS+PALETTE_BITS-1:0] vox_rdata;
   logic                                pal_rd;
   logic [PALETTE_BITS-1:0]             pal_addr;
   logic [PIXEL_BITS-1:0]               pal_rdata;
   logic [COORD_BITS-1:0]               voxel_x;
   logic [COORD_BITS-1:0]               voxel_y;
   logic [COORD_BITS-1:0]               voxel_z;
   logic [PALETTE_BITS-1:0]             voxel_id;
   logic [PIXEL_BITS-1:0]               palette_entry;
   logic                                do_rasterize;
   logic                                do_shade;
   logic                                rasterizing_done;
   logic                                shading_done;
   logic                                busy;
   logic                                frame_done;

   modport master (
      input  start, num_voxels, num_palette,
      input  vox_rdata, pal_rdata,
      input  rasterizing_done, shading_done,
      output vox_rd, vox_addr, pal_rd, pal_addr,
      output voxel_x, voxel_y, voxel_z, voxel_id,
      output palette_entry,
      output do_rasterize, do_shade,
      output busy, frame_done
   );

   modport slave (
      output start, num_voxels, num_palette,
      output vox_rdata, pal_rdata,
      output rasterizing_done, shading_done,
      input  vox_rd, vox_addr, pal_rd, pal_addr,
      input  voxel_x, voxel_y, voxel_z, voxel_id,
      input  palette_entry,
      input  do_rasterize, do_shade,
      input  busy, frame_done
   );

endinterface

// File: rtl/shader_dispatcher.sv
// Frame sequencer: walks the voxel list for rasterization, then the palette
// for shading, broadcasting each item to the pixel shaders.
module shader_dispatcher
   import gpu::*;
#(
   parameter int COORD_BITS   = COORD_BITS_D,
   parameter int PALETTE_BITS = PALETTE_BITS_D,
   parameter int PIXEL_BITS   = PIXEL_BITS_D,
   parameter int ADDR_BITS    = ADDR_BITS_D
) (
   input logic                 clock,
   input logic                 reset,
   shader_dispatcher_if.master bus
);

   localparam int C  = COORD_BITS;
   localparam int P  = PALETTE_BITS;
   // One extra bit so neither list length can wrap the index
   localparam int IW = ((ADDR_BITS > P) ? ADDR_BITS : P) + 1;

   dispatch_state_t state;
   dispatch_state_t nstate;

   logic [IW-1:0]         index;
   logic [IW-1:0]         idx_inc;
   logic [ADDR_BITS:0]    nv_q;
   logic [P-1:0]          np_q;
   logic [C-1:0]          vx_q;
   logic [C-1:0]          vy_q;
   logic [C-1:0]          vz_q;
   logic [P-1:0]          vid_q;
   logic [PIXEL_BITS-1:0] pe_q;
   logic                  vox_last;
   logic                  pal_last;
   logic                  vox_empty;
   dispatch_state_t       r_exit;

   assign idx_inc   = index + IW'(1);
   assign vox_last  = (idx_inc == IW'(nv_q));
   assign pal_last  = (idx_inc > IW'(np_q));
   assign vox_empty = (bus.vox_rdata[P-1:0] == '0);
   assign r_exit    = (np_q == '0) ? DONE : S_FETCH;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:
            if (bus.start) begin
               if (bus.num_voxels != '0)       nstate = R_FETCH;
               else if (bus.num_palette != '0) nstate = S_FETCH;
               else                            nstate = DONE;
            end
         R_FETCH: nstate = R_LATCH;
         R_LATCH:
            if (vox_empty) nstate = vox_last ? r_exit : R_FETCH;
            else           nstate = RASTER;
         RASTER:
            if (bus.rasterizing_done)
               nstate = vox_last ? r_exit : R_FETCH;
         S_FETCH: nstate = S_LATCH;
         S_LATCH: nstate = SHADE;
         SHADE:
            if (bus.shading_done)
               nstate = pal_last ? DONE : S_FETCH;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         index <= '0;
         nv_q  <= '0;
         np_q  <= '0;
         vx_q  <= '0;
         vy_q  <= '0;
         vz_q  <= '0;
         vid_q <= '0;
         pe_q  <= '0;
      end else begin
         unique case (state)
            IDLE:
               if (bus.start) begin
                  nv_q  <= bus.num_voxels;
                  np_q  <= bus.num_palette;
                  index <= (bus.num_voxels == '0) ? IW'(1) : '0;
               end
            R_LATCH: begin
               vx_q  <= bus.vox_rdata[3*C+P-1:2*C+P];
               vy_q  <= bus.vox_rdata[2*C+P-1:C+P];
               vz_q  <= bus.vox_rdata[C+P-1:P];
               vid_q <= bus.vox_rdata[P-1:0];
               if (vox_empty)
                  index <= vox_last ? IW'(1) : idx_inc;
            end
            RASTER:
               if (bus.rasterizing_done)
                  index <= vox_last ? IW'(1) : idx_inc;
            S_LATCH: begin
               vid_q <= index[P-1:0];
               pe_q  <= bus.pal_rdata;
            end
            SHADE:
               if (bus.shading_done)
                  index <= idx_inc;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.vox_rd        = (state == R_FETCH);
      bus.pal_rd        = (state == S_FETCH);
      bus.do_rasterize  = (state == RASTER);
      bus.do_shade      = (state == SHADE);
      bus.busy          = (state != IDLE);
      bus.frame_done    = (state == DONE);
      bus.vox_addr      = bus.vox_rd ? index[ADDR_BITS-1:0] : '0;
      bus.pal_addr      = bus.pal_rd ? index[P-1:0] : '0;
      bus.voxel_x       = vx_q;
      bus.voxel_y       = vy_q;
      bus.voxel_z       = vz_q;
      bus.voxel_id      = vid_q;
      bus.palette_entry = pe_q;
   end

endmodule

// File: tb/tb_shader_dispatcher.sv
// Bench for shader_dispatcher: RAM and shader models, scoreboard of broadcast events.
module tb_shader_dispatcher;
   import gpu::*;

   typedef struct packed {
      logic        kind;
      logic [31:0] data;
   } ev_t;

   typedef struct {
      int               nv;
      int               np;
      logic [3:0][31:0] v;
      bit               inj;
      int               exp_r;
   } tc_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   shader_dispatcher_if #(
      .COORD_BITS(8), .PALETTE_BITS(8),
      .PIXEL_BITS(8), .ADDR_BITS(12)
   ) bus ();

   shader_dispatcher #(
      .COORD_BITS(8), .PALETTE_BITS(8),
      .PIXEL_BITS(8), .ADDR_BITS(12)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   ev_t exp_q[$];
   tc_t tcs[7];

   logic [31:0] vram[0:3];
   logic [7:0]  pram[0:255];

   logic rdone_m = 1'b0;
   logic sdone_m = 1'b0;
   logic rdone_inj;
   logic sdone_inj;
   int   rc = 0;
   int   sc = 0;

   int   r_tot = 0;
   int   s_tot = 0;
   int   vrd_tot = 0;
   int   prd_tot = 0;
   int   frames = 0;
   int   vcnt[4] = '{0, 0, 0, 0};
   bit   sb_on = 1'b1;
   logic prev_r = 1'b0;
   logic prev_s = 1'b0;

   assign bus.rasterizing_done = rdone_m | rdone_inj;
   assign bus.shading_done     = sdone_m | sdone_inj;

   // RAMs with one-cycle read latency
   always @(posedge clock) begin
      if (bus.vox_rd) bus.vox_rdata <= vram[bus.vox_addr[1:0]];
      if (bus.pal_rd) bus.pal_rdata <= pram[bus.pal_addr];
   end

   // Shader array model: done pulse 4 cycles into each command
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         rc <= 0; rdone_m <= 1'b0;
         sc <= 0; sdone_m <= 1'b0;
      end else begin
         if (rdone_m) begin
            rdone_m <= 1'b0; rc <= 0;
         end else if (bus.do_rasterize) begin
            rc <= rc + 1;
            if (rc == 3) rdone_m <= 1'b1;
         end else rc <= 0;
         if (sdone_m) begin
            sdone_m <= 1'b0; sc <= 0;
         end else if (bus.do_shade) begin
            sc <= sc + 1;
            if (sc == 3) sdone_m <= 1'b1;
         end else sc <= 0;
      end
   end

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h, required %h", nm, act, req);
      end
   endtask

   task automatic sb_cmp(input logic kind, input logic [31:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_unexpected: actual kind %0d data %h, required none",
                  kind, d);
      end else begin
         e = exp_q.pop_front();
         check("sb_kind", 32'(kind), 32'(e.kind));
         check("sb_data", d, e.data);
      end
   endtask

   always @(negedge clock) begin
      check("excl_cmd", 32'(bus.do_rasterize & bus.do_shade), 32'd0);
      check("excl_rd", 32'(bus.vox_rd & bus.pal_rd), 32'd0);
      if (bus.vox_rd) begin
         vrd_tot <= vrd_tot + 1;
         if (bus.vox_addr < 12'd4)
            vcnt[bus.vox_addr[1:0]] <= vcnt[bus.vox_addr[1:0]] + 1;
      end
      if (bus.pal_rd) prd_tot <= prd_tot + 1;
      if (bus.frame_done) frames <= frames + 1;
      if (bus.do_rasterize && !prev_r) begin
         r_tot <= r_tot + 1;
         if (sb_on)
            sb_cmp(1'b0, {bus.voxel_x, bus.voxel_y,
                          bus.voxel_z, bus.voxel_id});
      end
      if (bus.do_shade && !prev_s) begin
         s_tot <= s_tot + 1;
         if (sb_on)
            sb_cmp(1'b1, {16'h0, bus.voxel_id, bus.palette_entry});
      end
      prev_r <= bus.do_rasterize;
      prev_s <= bus.do_shade;
   end

   function automatic logic [31:0] vx(input int x, input int y,
                                      input int z, input int id);
      return {8'(x), 8'(y), 8'(z), 8'(id)};
   endfunction

   function automatic void set_tc(input int i, input int nv, input int np,
                                  input bit inj, input int er,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [31:0] c);
      tcs[i].nv    = nv;
      tcs[i].np    = np;
      tcs[i].inj   = inj;
      tcs[i].exp_r = er;
      tcs[i].v[0]  = a;
      tcs[i].v[1]  = b;
      tcs[i].v[2]  = c;
      tcs[i].v[3]  = 32'h0;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"}, 32'({bus.do_rasterize, bus.do_shade, bus.vox_rd,
                                bus.pal_rd, bus.busy, bus.frame_done}), 32'd0);
      check({tag, "_voxel"}, {bus.voxel_x, bus.voxel_y,
                              bus.voxel_z, bus.voxel_id}, 32'd0);
      check({tag, "_pe"}, 32'(bus.palette_entry), 32'd0);
      check({tag, "_addr"}, 32'({bus.vox_addr, bus.pal_addr}), 32'd0);
   endtask

   task automatic inject();
      int c;
      c = 0;
      while (!bus.do_rasterize && c < 200) begin
         @(negedge clock); c++;
      end
      check("inj_raster_seen", 32'(bus.do_rasterize), 32'd1);
      sdone_inj = 1'b1;
      bus.start = 1'b1;
      bus.num_voxels = '0;
      bus.num_palette = '0;
      @(negedge clock);
      sdone_inj = 1'b0;
      bus.start = 1'b0;
      c = 0;
      while (!bus.do_shade && c < 400) begin
         @(negedge clock); c++;
      end
      check("inj_shade_seen", 32'(bus.do_shade), 32'd1);
      rdone_inj = 1'b1;
      bus.start = 1'b1;
      @(negedge clock);
      rdone_inj = 1'b0;
      bus.start = 1'b0;
   endtask

   task automatic run_case(input int k);
      tc_t t;
      int  f0, r0, s0, v0, p0, c;
      int  vc0[4];
      t = tcs[k];
      for (int a = 0; a < 4; a++) begin
         vram[a] = t.v[a];
         vc0[a]  = vcnt[a];
      end
      for (int a = 0; a < t.nv; a++)
         if (t.v[a][7:0] != 8'h0) exp_q.push_back('{1'b0, t.v[a]});
      for (int p = 1; p <= t.np; p++)
         exp_q.push_back('{1'b1, {16'h0, 8'(p), pram[p]}});
      f0 = frames; r0 = r_tot; s0 = s_tot;
      v0 = vrd_tot; p0 = prd_tot;

      @(negedge clock);
      bus.start = 1'b1;
      bus.num_voxels = 13'(t.nv);
      bus.num_palette = 8'(t.np);
      @(posedge clock);
      #1 bus.start = 1'b0;
      check("lat_busy", 32'(bus.busy), 32'd1);
      if (t.nv > 0) begin
         check("lat_vox_rd", 32'({bus.vox_rd, bus.vox_addr}), 32'h1000);
      end else if (t.np > 0) begin
         check("lat_pal_rd", 32'({bus.pal_rd, bus.pal_addr}), 32'h101);
      end else begin
         check("lat_frame_done", 32'(bus.frame_done), 32'd1);
      end
      if (t.nv > 0 && t.v[0][7:0] != 8'h0) begin
         @(posedge clock);
         #1 check("lat_r_latch", 32'({bus.vox_rd, bus.do_rasterize}), 32'd0);
         @(posedge clock);
         #1 check("lat_do_rasterize", 32'(bus.do_rasterize), 32'd1);
      end

      fork
         begin
            c = 0;
            while (frames == f0 && c < 20000) begin
               @(negedge clock); c++;
            end
         end
         begin
            if (t.inj) inject();
         end
      join
      repeat (3) @(negedge clock);

      check("frame_cnt", 32'(frames - f0), 32'd1);
      check("sb_left", 32'(exp_q.size()), 32'd0);
      check("raster_windows", 32'(r_tot - r0), 32'(t.exp_r));
      check("shade_windows", 32'(s_tot - s0), 32'(t.np));
      check("vox_rd_cnt", 32'(vrd_tot - v0), 32'(t.nv));
      check("pal_rd_cnt", 32'(prd_tot - p0), 32'(t.np));
      for (int a = 0; a < 4; a++)
         check("vox_addr_read", 32'(vcnt[a] - vc0[a]),
               (a < t.nv) ? 32'd1 : 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int c, r0;
      bus.start = 1'b0;
      bus.num_voxels = '0;
      bus.num_palette = '0;
      rdone_inj = 1'b0;
      sdone_inj = 1'b0;
      for (int i = 0; i < 256; i++) pram[i] = 8'(i * 17);
      for (int i = 0; i < 4; i++) vram[i] = 32'h0;

      set_tc(0, 3, 2, 1'b0, 3, vx(0,0,0,1), vx(2,2,2,2), vx(0,0,0,1));
      set_tc(1, 0, 0, 1'b0, 0, 32'h0, 32'h0, 32'h0);
      set_tc(2, 3, 2, 1'b0, 2, vx(1,2,3,1), vx(9,9,9,0), vx(4,5,6,2));
      set_tc(3, 3, 2, 1'b1, 3, vx(0,0,0,1), vx(2,2,2,2), vx(0,0,0,1));
      set_tc(4, 0, 3, 1'b0, 0, 32'h0, 32'h0, 32'h0);
      set_tc(5, 2, 0, 1'b0, 0, vx(7,7,7,0), vx(8,8,8,0), 32'h0);
      set_tc(6, 0, 255, 1'b0, 0, 32'h0, 32'h0, 32'h0);

      repeat (3) @(negedge clock);
      check_reset_outputs("reset_state");
      reset = 1'b0;
      @(negedge clock);

      for (int k = 0; k < 7; k++) run_case(k);

      // Abort a pass during its second raster window, then rerun it
      sb_on = 1'b0;
      for (int a = 0; a < 4; a++) vram[a] = tcs[0].v[a];
      r0 = r_tot;
      @(negedge clock);
      bus.start = 1'b1;
      bus.num_voxels = 13'd3;
      bus.num_palette = 8'd2;
      @(negedge clock);
      bus.start = 1'b0;
      c = 0;
      while (r_tot < r0 + 2 && c < 200) begin
         @(negedge clock); c++;
      end
      check("rst_in_raster2", 32'({bus.do_rasterize, bus.voxel_id}), 32'h102);
      reset = 1'b1;
      #1 check_reset_outputs("mid_reset");
      @(negedge clock);
      check_reset_outputs("mid_reset_held");
      reset = 1'b0;
      exp_q.delete();
      sb_on = 1'b1;
      @(negedge clock);
      run_case(0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
